// File: rtl/control_sequencer.sv
//==============================================================================
// Module      : control_sequencer
// Description : Hardwired Moore control unit for the Datapath. It sequences
//               instruction fetch (T0-T2) and then dispatches on IR[31:27]:
//               R-format ALU ops, immediate ALU ops, nop and halt.
//               Optional macro MEM_HANDSHAKE_EN: T1 waits for Mem_ready.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module control_sequencer #(
    parameter int OPC_W    = 5,
    parameter int ALU_OP_W = 4
) (
    input  logic                i_Clock,
    input  logic                i_Reset,
    input  logic [31:0]         i_IR,
    input  logic                i_Stop,
    input  logic                i_Mem_ready,
    output logic                o_PCout,
    output logic                o_Zlowout,
    output logic                o_MDRout,
    output logic                o_Cout,
    output logic                o_MARin,
    output logic                o_Zin,
    output logic                o_PCin,
    output logic                o_MDRin,
    output logic                o_IRin,
    output logic                o_Yin,
    output logic                o_IncPC,
    output logic                o_Read,
    output logic                o_Gra,
    output logic                o_Grb,
    output logic                o_Grc,
    output logic                o_Rin,
    output logic                o_Rout,
    output logic [ALU_OP_W-1:0] o_ALU_op,
    output logic                o_Run
);

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_T0    = 3'd1,
        S_T1    = 3'd2,
        S_T2    = 3'd3,
        S_T3    = 3'd4,
        S_T4    = 3'd5,
        S_T5    = 3'd6,
        S_HALT  = 3'd7
    } state_t;

    localparam logic [OPC_W-1:0] c_OP_ADD  = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] c_OP_SUB  = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] c_OP_AND  = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] c_OP_OR   = OPC_W'(5'b00110);
    localparam logic [OPC_W-1:0] c_OP_ADDI = OPC_W'(5'b01100);
    localparam logic [OPC_W-1:0] c_OP_ANDI = OPC_W'(5'b01101);
    localparam logic [OPC_W-1:0] c_OP_ORI  = OPC_W'(5'b01110);
    localparam logic [OPC_W-1:0] c_OP_HALT = OPC_W'(5'b10111);

    localparam logic [ALU_OP_W-1:0] c_ALU_NONE = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] c_ALU_ADD  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] c_ALU_SUB  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] c_ALU_AND  = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] c_ALU_OR   = ALU_OP_W'(4);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_stop_pend;
    logic [OPC_W-1:0]      w_opcode;
    logic                  w_is_rfmt;
    logic                  w_is_imm;
    logic [ALU_OP_W-1:0]   w_alu_sel;
    logic                  w_unused_bits;

    assign w_opcode = i_IR[31 -: OPC_W];

    // Opcode class and ALU function decode; nop and unlisted opcodes fall through as "no ALU op"
    always_comb begin
        w_is_rfmt = 1'b0;
        w_is_imm  = 1'b0;
        w_alu_sel = c_ALU_NONE;
        case (w_opcode)
            c_OP_ADD:  begin w_is_rfmt = 1'b1; w_alu_sel = c_ALU_ADD; end
            c_OP_SUB:  begin w_is_rfmt = 1'b1; w_alu_sel = c_ALU_SUB; end
            c_OP_AND:  begin w_is_rfmt = 1'b1; w_alu_sel = c_ALU_AND; end
            c_OP_OR:   begin w_is_rfmt = 1'b1; w_alu_sel = c_ALU_OR;  end
            c_OP_ADDI: begin w_is_imm  = 1'b1; w_alu_sel = c_ALU_ADD; end
            c_OP_ANDI: begin w_is_imm  = 1'b1; w_alu_sel = c_ALU_AND; end
            c_OP_ORI:  begin w_is_imm  = 1'b1; w_alu_sel = c_ALU_OR;  end
            default:   ;
        endcase
    end

`ifdef MEM_HANDSHAKE_EN
    assign w_unused_bits = ^i_IR[31-OPC_W:0];
`else
    // Mem_ready has no effect when T1 is a fixed single cycle
    assign w_unused_bits = ^{i_IR[31-OPC_W:0], i_Mem_ready};
`endif

    // State register; reset aborts any instruction immediately
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) r_state <= S_RESET;
        else         r_state <= w_next_state;
    end

    // Sticky halt request; only reset clears it, so a one-cycle Stop pulse is never lost
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) r_stop_pend <= 1'b0;
        else         r_stop_pend <= r_stop_pend | i_Stop;
    end

    // Next-state and Moore output decode; every strobe defaults low
    always_comb begin
        w_next_state = r_state;
        o_PCout   = 1'b0;
        o_Zlowout = 1'b0;
        o_MDRout  = 1'b0;
        o_Cout    = 1'b0;
        o_MARin   = 1'b0;
        o_Zin     = 1'b0;
        o_PCin    = 1'b0;
        o_MDRin   = 1'b0;
        o_IRin    = 1'b0;
        o_Yin     = 1'b0;
        o_IncPC   = 1'b0;
        o_Read    = 1'b0;
        o_Gra     = 1'b0;
        o_Grb     = 1'b0;
        o_Grc     = 1'b0;
        o_Rin     = 1'b0;
        o_Rout    = 1'b0;
        o_ALU_op  = c_ALU_NONE;
        o_Run     = 1'b1;
        case (r_state)
            S_RESET: begin
                o_Run        = 1'b0;
                w_next_state = S_T0;
            end
            S_T0: begin
                o_PCout      = 1'b1;
                o_MARin      = 1'b1;
                o_IncPC      = 1'b1;
                o_Zin        = 1'b1;
                w_next_state = S_T1;
            end
            S_T1: begin
                o_Zlowout = 1'b1;
                o_PCin    = 1'b1;
                o_Read    = 1'b1;
                o_MDRin   = 1'b1;
`ifdef MEM_HANDSHAKE_EN
                w_next_state = i_Mem_ready ? S_T2 : S_T1;
`else
                w_next_state = S_T2;
`endif
            end
            S_T2: begin
                o_MDRout     = 1'b1;
                o_IRin       = 1'b1;
                w_next_state = S_T3;
            end
            S_T3: begin
                if (w_is_rfmt || w_is_imm) begin
                    o_Grb        = 1'b1;
                    o_Rout       = 1'b1;
                    o_Yin        = 1'b1;
                    w_next_state = S_T4;
                end else if (w_opcode == c_OP_HALT) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = r_stop_pend ? S_HALT : S_T0;
                end
            end
            S_T4: begin
                if (w_is_rfmt) begin
                    o_Grc  = 1'b1;
                    o_Rout = 1'b1;
                end else if (w_is_imm) begin
                    o_Cout = 1'b1;
                end
                o_Zin        = w_is_rfmt | w_is_imm;
                o_ALU_op     = w_alu_sel;
                w_next_state = S_T5;
            end
            S_T5: begin
                o_Zlowout    = 1'b1;
                o_Gra        = 1'b1;
                o_Rin        = 1'b1;
                w_next_state = r_stop_pend ? S_HALT : S_T0;
            end
            S_HALT: begin
                o_Run        = 1'b0;
                w_next_state = S_HALT;
            end
            default: begin
                o_Run        = 1'b0;
                w_next_state = S_RESET;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
//==============================================================================
// Module      : tb_control_sequencer
// Description : Self-checking bench for control_sequencer. A phase-counting
//               reference model predicts every strobe each cycle from the
//               instruction-level rules. Define MEM_HANDSHAKE_EN to exercise
//               the T1 memory wait.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stop = 1'b0;
    logic        mem_ready = 1'b1;
    logic [31:0] ir = 32'hB000_0000;

    logic PCout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin;
    logic IncPC, Read, Gra, Grb, Grc, Rin, Rout, Run;
    logic [3:0] ALU_op;

    always #5 clk = ~clk;

    control_sequencer #(.OPC_W(5), .ALU_OP_W(4)) dut (
        .i_Clock(clk), .i_Reset(rst), .i_IR(ir), .i_Stop(stop), .i_Mem_ready(mem_ready),
        .o_PCout(PCout), .o_Zlowout(Zlowout), .o_MDRout(MDRout), .o_Cout(Cout),
        .o_MARin(MARin), .o_Zin(Zin), .o_PCin(PCin), .o_MDRin(MDRin), .o_IRin(IRin),
        .o_Yin(Yin), .o_IncPC(IncPC), .o_Read(Read), .o_Gra(Gra), .o_Grb(Grb),
        .o_Grc(Grc), .o_Rin(Rin), .o_Rout(Rout), .o_ALU_op(ALU_op), .o_Run(Run)
    );

    wire [21:0] obs = {PCout, Zlowout, MDRout, Cout, MARin, Zin, PCin, MDRin, IRin, Yin,
                       IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALU_op, Run};

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: phase -1 = reset, 0..5 = T0..T5, 6 = halted
    int m_phase = -1;
    bit m_pend  = 1'b0;

    // 0 = nop/unlisted, 1 = register ALU op, 2 = immediate ALU op, 3 = halt
    function automatic int op_class(input logic [31:0] i);
        case (i[31:27])
            5'd3, 5'd4, 5'd5, 5'd6: return 1;
            5'd12, 5'd13, 5'd14:    return 2;
            5'd23:                  return 3;
            default:                return 0;
        endcase
    endfunction

    function automatic logic [3:0] alu_code(input logic [31:0] i);
        case (i[31:27])
            5'd3, 5'd12: return 4'd1;
            5'd4:        return 4'd2;
            5'd5, 5'd13: return 4'd3;
            5'd6, 5'd14: return 4'd4;
            default:     return 4'd0;
        endcase
    endfunction

    function automatic logic [21:0] expect_vec(input int ph, input logic [31:0] i);
        logic pco, zlo, mdro, co, mari, zi, pci, mdri, iri, yi, inc, rd;
        logic ga, gb, gc, ri, ro, run;
        logic [3:0] alu;
        int cls;
        {pco, zlo, mdro, co, mari, zi, pci, mdri, iri, yi, inc, rd} = '0;
        {ga, gb, gc, ri, ro} = '0;
        alu = 4'd0;
        cls = op_class(i);
        run = (ph >= 0 && ph <= 5);
        case (ph)
            0: begin pco = 1; mari = 1; inc = 1; zi = 1; end
            1: begin zlo = 1; pci = 1; rd = 1; mdri = 1; end
            2: begin mdro = 1; iri = 1; end
            3: if (cls == 1 || cls == 2) begin gb = 1; ro = 1; yi = 1; end
            4: begin
                if (cls == 1) begin gc = 1; ro = 1; zi = 1; alu = alu_code(i); end
                if (cls == 2) begin co = 1; zi = 1; alu = alu_code(i); end
            end
            5: begin zlo = 1; ga = 1; ri = 1; end
            default: ;
        endcase
        return {pco, zlo, mdro, co, mari, zi, pci, mdri, iri, yi, inc, rd,
                ga, gb, gc, ri, ro, alu, run};
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic model_edge();
        bit old_pend;
        int cls;
        if (rst) begin
            m_phase = -1;
            m_pend  = 1'b0;
            return;
        end
        old_pend = m_pend;
        m_pend   = m_pend | stop;
        cls      = op_class(ir);
        case (m_phase)
            -1: m_phase = 0;
            0:  m_phase = 1;
`ifdef MEM_HANDSHAKE_EN
            1:  m_phase = mem_ready ? 2 : 1;
`else
            1:  m_phase = 2;
`endif
            2:  m_phase = 3;
            3:  begin
                if (cls == 1 || cls == 2) m_phase = 4;
                else if (cls == 3)        m_phase = 6;
                else                      m_phase = old_pend ? 6 : 0;
            end
            4:  m_phase = 5;
            5:  m_phase = old_pend ? 6 : 0;
            default: m_phase = 6;
        endcase
    endtask

    task automatic check(input string tag);
        logic [21:0] exp_v;
        exp_v = expect_vec(m_phase, ir);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (model phase %0d)", tag, obs, exp_v, m_phase);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    // Asserts reset between edges; the asynchronous clear must be visible at once
    task automatic reset_now(input string tag);
        rst = 1'b1;
        #1;
        model_edge();
        check(tag);
    endtask

    initial begin
        // 1: reset held, then reset mid-T4 of an add
        #2;
        reset_now("reset_assert");
        cycles(3, "reset_hold");
        rst = 1'b0;
        cycle("reset_release_T0");
        ir = 32'h1891_8000;
        cycles(4, "add_to_T4");
        reset_now("reset_mid_T4");
        cycles(2, "reset_mid_hold");
        rst = 1'b0;
        cycle("restart_T0");

        // 2: and R1,R2,R3 then back to T0
        ir = 32'h2891_8000;
        cycles(6, "and_seq");

        // 3: addi, six cycles back to T0
        ir = 32'h6091_8000;
        cycles(6, "addi_seq");

        // 4: nop then illegal, four cycles each
        ir = 32'hB000_0000;
        cycles(4, "nop_seq");
        ir = 32'hF800_0000;
        cycles(4, "illegal_seq");

        // 5: Stop pulsed during T1 of an add, then the halt opcode
        ir = 32'h1891_8000;
        cycle("stop_add_T1");
        stop = 1'b1;
        cycle("stop_add_T2");
        stop = 1'b0;
        cycles(4, "stop_add_finish");
        cycles(3, "stop_halt_hold");
        reset_now("stop_reset");
        cycle("stop_reset_hold");
        rst = 1'b0;
        cycle("halt_op_T0");
        ir = 32'hB800_0000;
        cycles(4, "halt_op_seq");
        cycles(2, "halt_op_hold");
        reset_now("halt_reset");
        rst = 1'b0;
        cycle("halt_restart_T0");

`ifdef MEM_HANDSHAKE_EN
        // 6: memory wait stretches T1
        ir = 32'h1891_8000;
        mem_ready = 1'b0;
        cycles(4, "mem_wait_T1");
        mem_ready = 1'b1;
        cycle("mem_wait_T2");
        cycles(4, "mem_wait_finish");
`endif

        // Randomized stream against the model
        for (int n = 0; n < 2000; n++) begin
            stop      = ($urandom_range(0, 39) == 0);
            mem_ready = ($urandom_range(0, 2) != 0);
            if (m_phase == 0) begin
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 8))
                        0: ir[31:27] = 5'd3;
                        1: ir[31:27] = 5'd4;
                        2: ir[31:27] = 5'd5;
                        3: ir[31:27] = 5'd6;
                        4: ir[31:27] = 5'd12;
                        5: ir[31:27] = 5'd13;
                        6: ir[31:27] = 5'd14;
                        7: ir[31:27] = 5'd22;
                        default: ir[31:27] = 5'd23;
                    endcase
                end else begin
                    ir[31:27] = 5'($urandom_range(0, 31));
                end
                ir[26:0] = 27'($urandom);
            end
            if (rst) begin
                rst = 1'b0;
            end else if ((m_phase == 6 && $urandom_range(0, 3) == 0) ||
                         $urandom_range(0, 299) == 0) begin
                reset_now("rand_reset");
            end
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
